// File: rtl/id_decode_pkg.sv
// Shared definitions for the instruction-decode stage: ALU codes, opcodes,
// funct fields, and the ID/EX control bundle carried in the pipeline register.
package id_decode_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_BEQ = 4'b1000;
  localparam logic [3:0] ALU_BNE = 4'b1001;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S, IMM_B} imm_fmt_e;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_byte;
    logic       branch;
    logic       illegal;
  } idex_ctrl_t;

  // {supported, alu code} for the funct3 arithmetic group shared by R and I types
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      F3_ADD:  alu_from_f3 = {1'b1, ALU_ADD};
      F3_SLL:  alu_from_f3 = {1'b1, ALU_SLL};
      F3_SLT:  alu_from_f3 = {1'b1, ALU_SLT};
      F3_XOR:  alu_from_f3 = {1'b1, ALU_XOR};
      F3_SRL:  alu_from_f3 = {1'b1, ALU_SRL};
      F3_OR:   alu_from_f3 = {1'b1, ALU_OR};
      F3_AND:  alu_from_f3 = {1'b1, ALU_AND};
      default: alu_from_f3 = {1'b0, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/id_decode_comb.sv
// Pure combinational decoder: instruction word to control bundle, register
// indices and sign-extended immediate. Unsupported encodings decode as a NOP.
module id_decode_comb
  import id_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output idex_ctrl_t      ctrl_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] f3_alu;
  logic       legal;
  imm_fmt_e   fmt;
  idex_ctrl_t ctrl;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rd_o   = inst_i[11:7];
  assign rs1_o  = inst_i[19:15];
  assign rs2_o  = inst_i[24:20];
  assign f3_alu = alu_from_f3(funct3);

  always_comb begin
    ctrl  = '0;
    fmt   = IMM_NONE;
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct7 == F7_SUB && funct3 == F3_ADD) begin
          legal         = 1'b1;
          ctrl.alu_ctrl = ALU_SUB;
        end else if (funct7 == F7_BASE && f3_alu[4]) begin
          legal         = 1'b1;
          ctrl.alu_ctrl = f3_alu[3:0];
        end
        ctrl.reg_write = 1'b1;
      end
      OP_ITYPE: begin
        // Shift-immediates carry funct7 in imm[11:5]; only the logical forms exist here
        legal = f3_alu[4] && ((funct3 != F3_SLL && funct3 != F3_SRL) || funct7 == F7_BASE);
        ctrl.alu_ctrl    = f3_alu[3:0];
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
        fmt              = IMM_I;
      end
      OP_LOAD: begin
        legal            = (funct3 == F3_BYTE) || (funct3 == F3_WORD);
        ctrl.alu_ctrl    = ALU_ADD;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.mem_byte    = (funct3 == F3_BYTE);
        fmt              = IMM_I;
      end
      OP_STORE: begin
        legal            = (funct3 == F3_BYTE) || (funct3 == F3_WORD);
        ctrl.alu_ctrl    = ALU_ADD;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_write   = 1'b1;
        ctrl.mem_byte    = (funct3 == F3_BYTE);
        fmt              = IMM_S;
      end
      OP_BRANCH: begin
        legal         = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
        ctrl.alu_ctrl = (funct3 == F3_BNE) ? ALU_BNE : ALU_BEQ;
        ctrl.branch   = 1'b1;
        fmt           = IMM_B;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      fmt          = IMM_NONE;
    end
    if (rd_o == 5'd0) ctrl.reg_write = 1'b0;
  end

  always_comb begin
    imm_o = '0;
    case (fmt)
      IMM_I:   imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
      IMM_S:   imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:   imm_o = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      default: imm_o = '0;
    endcase
  end

  assign ctrl_o = ctrl;

endmodule

// File: rtl/id_decode_stage.sv
// ID/EX pipeline stage: decoder plus registered slot with valid/ready and flush.
// Optional ID_ILLEGAL_TRAP_EN locks the input after an illegal instruction until reset.
module id_decode_stage
  import id_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] imm,
  output logic            alu_src_imm,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_byte,
  output logic            branch,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [PC_W-1:0] pc_out,
  output logic            illegal
);

  idex_ctrl_t      dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_rs1, dec_rs2, dec_rd;

  id_decode_comb #(.XLEN(XLEN)) u_dec (
    .inst_i (in_inst),
    .ctrl_o (dec_ctrl),
    .imm_o  (dec_imm),
    .rs1_o  (dec_rs1),
    .rs2_o  (dec_rs2),
    .rd_o   (dec_rd)
  );

  logic            valid_q, valid_d;
  idex_ctrl_t      ctrl_q, ctrl_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            accept, locked;

`ifdef ID_ILLEGAL_TRAP_EN
  logic trap_q, trap_d;

  // Sticky: only reset releases the lock, flush does not
  always_comb trap_d = trap_q | (accept && !flush && dec_ctrl.illegal);

  always_ff @(posedge clk) begin
    if (reset) trap_q <= 1'b0;
    else       trap_q <= trap_d;
  end

  assign locked = trap_q;
`else
  assign locked = 1'b0;
`endif

  assign in_ready = (!valid_q || out_ready) && !locked;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = dec_ctrl;
      imm_d   = dec_imm;
      rs1_d   = dec_rs1;
      rs2_d   = dec_rs2;
      rd_d    = dec_rd;
      pc_d    = in_pc;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid   = valid_q;
  assign alu_ctrl    = ctrl_q.alu_ctrl;
  assign imm         = imm_q;
  assign alu_src_imm = ctrl_q.alu_src_imm;
  assign reg_write   = ctrl_q.reg_write;
  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign mem_byte    = ctrl_q.mem_byte;
  assign branch      = ctrl_q.branch;
  assign illegal     = ctrl_q.illegal;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign pc_out      = pc_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: decode vectors, stall, flush, reset and illegal handling.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, imm, pc_out;
  logic [3:0]  alu_ctrl;
  logic        alu_src_imm, reg_write, mem_read, mem_write, mem_byte, branch, illegal;
  logic [4:0]  rs1, rs2, rd;
  int          checks = 0;
  int          failures = 0;

  id_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_ctrl(alu_ctrl), .imm(imm), .alu_src_imm(alu_src_imm),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte(mem_byte), .branch(branch), .rs1(rs1), .rs2(rs2), .rd(rd),
    .pc_out(pc_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_alu", alu_ctrl, 0);
    chk("rst_imm", imm, 0);
    chk("rst_ctl", {alu_src_imm, reg_write, mem_read, mem_write, mem_byte, branch}, 0);
    chk("rst_idx_pc", {rs1, rs2, rd, pc_out}, 0);
    reset = 1'b0;
    #1 chk("rst_ready", in_ready, 1);

    // ADD x3,x1,x2
    offer(32'h002081B3, 32'h100); step();
    chk("add_valid", out_valid, 1);
    chk("add_alu", alu_ctrl, 4'b0000);
    chk("add_idx", {rs1, rs2, rd}, {5'd1, 5'd2, 5'd3});
    chk("add_ctl", {reg_write, alu_src_imm}, 2'b10);
    chk("add_pc", pc_out, 32'h100);

    // SUB then ADDI back-to-back
    offer(32'h402081B3, 32'h104); step();
    chk("sub_alu", alu_ctrl, 4'b0110);
    chk("sub_pc", pc_out, 32'h104);
    offer(32'hFF100293, 32'h108); step();
    chk("addi_valid", out_valid, 1);
    chk("addi_alu", alu_ctrl, 4'b0000);
    chk("addi_imm", imm, 32'hFFFFFFF1);
    chk("addi_rd", rd, 5);
    chk("addi_ctl", {alu_src_imm, reg_write}, 2'b11);

    // Stall with BNE waiting
    out_ready = 1'b0;
    offer(32'h00209463, 32'h10C);
    #1 chk("stall_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_hold", {alu_ctrl, imm, pc_out}, {4'b0000, 32'hFFFFFFF1, 32'h108});
      chk("stall_ready_hold", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 chk("release_ready", in_ready, 1);
    step();
    chk("bne_alu", alu_ctrl, 4'b1001);
    chk("bne_ctl", {branch, reg_write, alu_src_imm}, 3'b100);
    chk("bne_imm", imm, 32'd8);
    chk("bne_pc", pc_out, 32'h10C);

    // SW x2,-4(x1)
    offer(32'hFE20AE23, 32'h110); step();
    chk("sw_imm", imm, 32'hFFFFFFFC);
    chk("sw_ctl", {mem_write, mem_read, reg_write, alu_src_imm, mem_byte}, 5'b10010);

    // LB x6,4(x1)
    offer(32'h00408303, 32'h114); step();
    chk("lb_imm", imm, 32'd4);
    chk("lb_ctl", {mem_read, mem_write, reg_write, alu_src_imm, mem_byte}, 5'b10111);
    chk("lb_rd", rd, 6);

    // ADD x0 keeps reg_write low
    offer(32'h00208033, 32'h118); step();
    chk("x0_regwrite", reg_write, 0);
    chk("x0_valid", out_valid, 1);

    // Flush wins over same-cycle accept
    offer(32'h402081B3, 32'h11C); flush = 1'b1; step();
    chk("flush_valid", out_valid, 0);
    chk("flush_nolatch", {alu_ctrl, pc_out}, {4'b0000, 32'h118});
    flush = 1'b0; in_valid = 1'b0; step();
    chk("idle_valid", out_valid, 0);

    // Reset in the middle of a stall
    offer(32'h402081B3, 32'h130); step();
    out_ready = 1'b0; offer(32'h002081B3, 32'h134); step();
    chk("pre_rst_alu", alu_ctrl, 4'b0110);
    reset = 1'b1; step();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_out", {alu_ctrl, pc_out, rd}, 0);
    reset = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    #1 chk("midrst_ready", in_ready, 1);

    // Illegal encoding
    offer(32'hFFFFFFFF, 32'h120); step();
    chk("ill_flag", illegal, 1);
    chk("ill_valid", out_valid, 1);
    chk("ill_alu", alu_ctrl, 4'b0000);
    chk("ill_ctl", {reg_write, mem_read, mem_write, branch}, 4'b0000);
    offer(32'h002081B3, 32'h124);
`ifdef ID_ILLEGAL_TRAP_EN
    #1 chk("trap_ready", in_ready, 0);
    step();
    chk("trap_drained", out_valid, 0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("trap_flush_ready", in_ready, 0);
    reset = 1'b1; step(); reset = 1'b0;
    #1 chk("trap_rst_ready", in_ready, 1);
`else
    #1 chk("noTrap_ready", in_ready, 1);
    step();
    chk("after_ill_valid", out_valid, 1);
    chk("after_ill", {illegal, pc_out}, {1'b0, 32'h124});
`endif
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
